// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multi-cycle RV32 control FSM (3-5 cycles per instr).
// Define RV_MC_BRANCH_UNSIGNED_EN to add bltu/bgeu to the branch decoder.
module riscv_mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       Neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUOp,
  output logic       Illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;

  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_MEM    = 2'b01;
  localparam logic [1:0] RS_ALURES = 2'b10;
  localparam logic [1:0] RS_IMM    = 2'b11;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RD1   = 2'b10;

  localparam logic [1:0] B_RD2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRPC,
    S_LUI
  } state_t;

  state_t state, state_n;

  logic       arith_ok;
  logic [2:0] arith_op;
  logic       br_ok;
  logic [2:0] br_op;
  logic       br_take;
  logic       legal;

  logic pcw, mw, irw, rw, ill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  // funct3 decode shared by EXECR and EXECI; sub only for R-type
  always_comb begin
    arith_ok = 1'b1;
    arith_op = ALU_ADD;
    unique case (funct3)
      3'b000: arith_op = (op == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111: arith_op = ALU_AND;
      3'b110: arith_op = ALU_OR;
      3'b100: arith_op = ALU_XOR;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      default: arith_ok = 1'b0;
    endcase
  end

  // slt-based compares take the branch when the ALU result is nonzero
  always_comb begin
    br_ok   = 1'b1;
    br_op   = ALU_SUB;
    br_take = 1'b0;
    unique case (funct3)
      3'b000: br_take = Zero;
      3'b001: br_take = !Zero;
      3'b100: begin br_op = ALU_SLT; br_take = !Zero; end
      3'b101: begin br_op = ALU_SLT; br_take = Zero;  end
`ifdef RV_MC_BRANCH_UNSIGNED_EN
      3'b110: begin br_op = ALU_SLTU; br_take = !Zero; end
      3'b111: begin br_op = ALU_SLTU; br_take = Zero;  end
`endif
      default: br_ok = 1'b0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    unique case (op)
      OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
      OP_R:    legal = arith_ok && !(funct7_5 && funct3 != 3'b000);
      OP_I:    legal = arith_ok;
      OP_BR:   legal = br_ok;
      OP_JAL, OP_JALR, OP_LUI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state;
    pcw       = 1'b0;
    mw        = 1'b0;
    irw       = 1'b0;
    rw        = 1'b0;
    ill       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RS_ALUOUT;
    ALUSrcA   = A_PC;
    ALUSrcB   = B_RD2;
    ImmSrc    = IMM_I;
    ALUOp     = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        irw       = 1'b1;
        pcw       = 1'b1;
        ALUSrcB   = B_FOUR;
        ResultSrc = RS_ALURES;
        state_n   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        if (!legal) begin
          ill     = 1'b1;
          state_n = S_FETCH;
        end else begin
          unique case (op)
            OP_LOAD, OP_STORE: state_n = S_MEMADR;
            OP_R:    state_n = S_EXECR;
            OP_I:    state_n = S_EXECI;
            OP_BR:   state_n = S_BRANCH;
            OP_JAL:  state_n = S_JAL;
            OP_JALR: state_n = S_JALR;
            OP_LUI:  state_n = S_LUI;
            default: state_n = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA = A_RD1;
        ALUSrcB = B_IMM;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        state_n = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RS_MEM;
        rw        = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc  = 1'b1;
        mw      = 1'b1;
        state_n = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = A_RD1;
        ALUOp   = arith_op;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = A_RD1;
        ALUSrcB = B_IMM;
        ALUOp   = arith_op;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        rw      = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = A_RD1;
        ALUOp   = br_op;
        pcw     = br_take;
        state_n = S_FETCH;
      end
      S_JAL: begin
        pcw     = 1'b1;
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_FOUR;
        state_n = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = A_RD1;
        ALUSrcB = B_IMM;
        state_n = S_JALRPC;
      end
      S_JALRPC: begin
        pcw     = 1'b1;
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_FOUR;
        state_n = S_ALUWB;
      end
      S_LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = RS_IMM;
        rw        = 1'b1;
        state_n   = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // reset kills every side effect at once, even mid-cycle
  assign PCWrite  = pcw & ~rst;
  assign MemWrite = mw  & ~rst;
  assign IRWrite  = irw & ~rst;
  assign RegWrite = rw  & ~rst;
  assign Illegal  = ill & ~rst;

  logic unused_neg;
  assign unused_neg = Neg;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb_riscv_mc_controller: random instruction stream vs per-instruction
// micro-step model, plus directed literal pins.
module tb_riscv_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       Neg;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUOp;

  riscv_mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7_5(funct7_5), .Zero(Zero), .Neg(Neg),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUOp(ALUOp), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm, aop;
    logic       ill;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  vec_t  exp_seq[8];
  int    exp_len;
  vec_t  exp_vec;
  logic  exp_valid = 1'b0;
  vec_t  cap[8];
  int    cap_n;
  int    cyc;
  string cur_name = "reset";

  always @(negedge clk) begin
    if (exp_valid) begin
      vec_t got;
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUOp, Illegal};
      if (cap_n < 8) cap[cap_n] = got;
      cap_n++;
      checks++;
      if (got !== exp_vec) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h required=%h",
                 cur_name, cyc, got, exp_vec);
      end
    end
  end

  task automatic pin(input string nm, input logic [2:0] got,
                     input logic [2:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL pin_%s got=%0d required=%0d", nm, got, req);
    end
  endtask

  function automatic logic arith_f3_ok(input logic [2:0] f);
    return f inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  endfunction

  function automatic logic is_legal(input logic [6:0] o,
                                    input logic [2:0] f, input logic f7);
    case (o)
      7'b0000011, 7'b0100011: return f == 3'd2;
      7'b0110011: return arith_f3_ok(f) && !(f7 && f != 3'd0);
      7'b0010011: return arith_f3_ok(f);
`ifdef RV_MC_BRANCH_UNSIGNED_EN
      7'b1100011: return f inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
`else
      7'b1100011: return f inside {3'd0, 3'd1, 3'd4, 3'd5};
`endif
      7'b1101111, 7'b1100111, 7'b0110111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] arith_alu(input logic [2:0] f,
                                           input logic sub);
    case (f)
      3'd0: return sub ? 3'd1 : 3'd0;
      3'd7: return 3'd2;
      3'd6: return 3'd3;
      3'd4: return 3'd6;
      3'd2: return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  // expected control word for each cycle of one instruction
  task automatic build(input logic [6:0] o, input logic [2:0] f,
                       input logic f7, input logic [4:0] zs);
    vec_t v, wb;
    int n;
    n = 0;
    wb = '0; wb.rw = 1'b1;
    v = '0; v.pcw = 1; v.irw = 1; v.sb = 2; v.rs = 2;
    exp_seq[n++] = v;
    v = '0; v.sa = 1; v.sb = 1; v.imm = (o == 7'b1101111) ? 3'd3 : 3'd2;
    v.ill = !is_legal(o, f, f7);
    exp_seq[n++] = v;
    if (!v.ill) begin
      case (o)
        7'b0000011, 7'b0100011: begin
          v = '0; v.sa = 2; v.sb = 1; v.imm = (o[5]) ? 3'd1 : 3'd0;
          exp_seq[n++] = v;
          if (o[5]) begin
            v = '0; v.adr = 1; v.mw = 1; exp_seq[n++] = v;
          end else begin
            v = '0; v.adr = 1; exp_seq[n++] = v;
            v = '0; v.rs = 1; v.rw = 1; exp_seq[n++] = v;
          end
        end
        7'b0110011: begin
          v = '0; v.sa = 2; v.aop = arith_alu(f, f7);
          exp_seq[n++] = v; exp_seq[n++] = wb;
        end
        7'b0010011: begin
          v = '0; v.sa = 2; v.sb = 1; v.aop = arith_alu(f, 1'b0);
          exp_seq[n++] = v; exp_seq[n++] = wb;
        end
        7'b1100011: begin
          v = '0; v.sa = 2;
          v.aop = (f[2:1] == 2'b00) ? 3'd1 : (f[1] ? 3'd5 : 3'd4);
          v.pcw = zs[n] ^ (f[0] ^ f[2]);
          exp_seq[n++] = v;
        end
        7'b1101111: begin
          v = '0; v.pcw = 1; v.sa = 1; v.sb = 2;
          exp_seq[n++] = v; exp_seq[n++] = wb;
        end
        7'b1100111: begin
          v = '0; v.sa = 2; v.sb = 1; exp_seq[n++] = v;
          v = '0; v.pcw = 1; v.sa = 1; v.sb = 2; exp_seq[n++] = v;
          exp_seq[n++] = wb;
        end
        default: begin
          v = '0; v.imm = 4; v.rs = 3; v.rw = 1; exp_seq[n++] = v;
        end
      endcase
    end
    exp_len = n;
  endtask

  localparam vec_t RST_VEC = 18'b0_0_0_0_0_10_00_10_000_000_0;

  // run one instruction starting at posedge+1 of its FETCH cycle
  task automatic run(input string nm, input logic [6:0] o,
                     input logic [2:0] f, input logic f7,
                     input logic [4:0] zs, input int abort_at);
    build(o, f, f7, zs);
    cur_name = nm;
    cap_n = 0;
    for (int k = 0; k < exp_len; k++) begin
      op = o; funct3 = f; funct7_5 = f7;
      Zero = zs[k]; Neg = 1'($urandom);
      cyc = k;
      exp_vec = exp_seq[k];
      if (k == abort_at) begin
        rst = 1'b1;
        exp_vec = RST_VEC;
      end
      exp_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      if (k == abort_at) break;
    end
  endtask

  logic [6:0] ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  initial begin
    rst = 1'b1; op = '0; funct3 = '0; funct7_5 = 1'b0;
    Zero = 1'b0; Neg = 1'b0;
    cap_n = 0; cyc = 0;
    exp_vec = RST_VEC; exp_valid = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    run("sub", 7'b0110011, 3'd0, 1'b1, 5'b0, -1);
    pin("rel_irw", {2'b0, cap[0].irw}, 3'd1);
    pin("rel_pcw", {2'b0, cap[0].pcw}, 3'd1);
    pin("dec_sa", {1'b0, cap[1].sa}, 3'd1);
    pin("sub_aop", cap[2].aop, 3'd1);
    pin("sub_rw", {2'b0, cap[3].rw}, 3'd1);

    run("lw", 7'b0000011, 3'd2, 1'b0, 5'b0, -1);
    pin("lw_adr", {2'b0, cap[3].adr}, 3'd1);
    pin("lw_rs", {1'b0, cap[4].rs}, 3'd1);
    pin("lw_rw", {2'b0, cap[4].rw}, 3'd1);

    run("beq_z1", 7'b1100011, 3'd0, 1'b0, 5'b00100, -1);
    pin("beq_pcw", {2'b0, cap[2].pcw}, 3'd1);
    run("bne_z1", 7'b1100011, 3'd1, 1'b0, 5'b00100, -1);
    pin("bne_pcw", {2'b0, cap[2].pcw}, 3'd0);
    run("blt", 7'b1100011, 3'd4, 1'b0, 5'b0, -1);
    pin("blt_aop", cap[2].aop, 3'd4);

    run("bltu", 7'b1100011, 3'd6, 1'b0, 5'b0, -1);
`ifdef RV_MC_BRANCH_UNSIGNED_EN
    pin("bltu_aop", cap[2].aop, 3'd5);
    pin("bltu_pcw", {2'b0, cap[2].pcw}, 3'd1);
`else
    pin("bltu_ill", {2'b0, cap[1].ill}, 3'd1);
    pin("bltu_len", 3'(cap_n), 3'd2);
`endif

    run("illegal", 7'b1111111, 3'd0, 1'b0, 5'b0, -1);
    pin("ill_pulse", {2'b0, cap[1].ill}, 3'd1);
    pin("ill_len", 3'(cap_n), 3'd2);

    run("sw_abort", 7'b0100011, 3'd2, 1'b0, 5'b0, 3);
    pin("abort_mw", {2'b0, cap[3].mw}, 3'd0);
    cur_name = "abort_hold";
    exp_vec = RST_VEC;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [6:0] o;
      int sel;
      sel = $urandom_range(0, 9);
      o = (sel < 8) ? ops[sel] : 7'($urandom);
      run("rand", o, 3'($urandom), 1'($urandom), 5'($urandom), -1);
    end

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
